// File: rtl/dds_step_ctrl_if.sv
// Bus between the front-panel/host side and the DDS step controller.
// Switch and host-load signals enter the controller; the step word and its flags leave it.
interface dds_step_ctrl_if #(
  parameter int WIDTH = 32
);
  // load_en is a one-cycle strobe with no backpressure: the controller always
  // takes load_value in the cycle load_en is high, so there is no ready signal.
  logic [5:0]       switch_n;
  logic             load_en;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] Step;
  logic             step_changed;
  logic             at_min;
  logic             at_max;

  modport master (
    output switch_n, load_en, load_value,
    input  Step, step_changed, at_min, at_max
  );

  modport slave (
    input  switch_n, load_en, load_value,
    output Step, step_changed, at_min, at_max
  );
endinterface

// File: rtl/dds_step_ctrl.sv
// Front-panel step control for the DDS: synchronises, debounces and auto-repeats
// six push-switches and turns them into a saturating phase-increment word.
module dds_step_ctrl #(
  parameter int unsigned WIDTH           = 32,
  parameter int unsigned STEP_MIN        = 10000,
  parameter int unsigned STEP_MAX        = 2000000,
  parameter int unsigned STEP_INIT       = 10000,
  parameter int unsigned INC_COARSE      = 10000,
  parameter int unsigned INC_MID         = 1000,
  parameter int unsigned INC_FINE        = 1,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic            clk,
  input  logic            reset,
  dds_step_ctrl_if.slave  bus
);

  localparam int unsigned DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned RP_TOP = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RP_W   = (RP_TOP > 1) ? $clog2(RP_TOP) : 1;

  localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RP_W-1:0]  RP_DLY_LD = RP_W'(REPEAT_DELAY - 1);
  localparam logic [RP_W-1:0]  RP_PER_LD = RP_W'(REPEAT_PERIOD - 1);

  localparam logic [WIDTH:0]   MIN_X  = (WIDTH+1)'(STEP_MIN);
  localparam logic [WIDTH:0]   MAX_X  = (WIDTH+1)'(STEP_MAX);
  localparam logic [WIDTH:0]   INC_C  = (WIDTH+1)'(INC_COARSE);
  localparam logic [WIDTH:0]   INC_M  = (WIDTH+1)'(INC_MID);
  localparam logic [WIDTH:0]   INC_F  = (WIDTH+1)'(INC_FINE);
  localparam logic [WIDTH-1:0] INIT_W = WIDTH'(STEP_INIT);

  logic [5:0]       sync1_q, sync2_q;
  logic [5:0]       deb_q, deb_prev_q;
  logic [DB_W-1:0]  db_cnt_q [6];
  logic [RP_W-1:0]  rp_cnt_q [6];

  logic [5:0]       press, rep_ev, ev;

  logic [WIDTH-1:0] step_q, step_d;
  logic             changed_q, at_min_q, at_max_q;

  function automatic logic [WIDTH-1:0] add_sat(input logic [WIDTH:0] s, input logic [WIDTH:0] inc);
    logic [WIDTH:0] sum;
    sum = s + inc;
    if (sum > MAX_X) sum = MAX_X;
    return sum[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] sub_sat(input logic [WIDTH:0] s, input logic [WIDTH:0] inc);
    logic [WIDTH:0] res;
    if (s < MIN_X + inc) res = MIN_X;
    else                 res = s - inc;
    return res[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] clamp(input logic [WIDTH:0] v);
    logic [WIDTH:0] res;
    res = v;
    if (v < MIN_X) res = MIN_X;
    if (v > MAX_X) res = MAX_X;
    return res[WIDTH-1:0];
  endfunction

  // A repeat fires whenever a held switch's countdown has expired; the press
  // cycle itself is excluded because the counter is still cleared then.
  always_comb begin
    press  = deb_prev_q & ~deb_q;
    rep_ev = '0;
    for (int i = 0; i < 6; i++) begin
      rep_ev[i] = ~deb_q[i] & ~press[i] & (rp_cnt_q[i] == '0);
    end
    ev = press | rep_ev;
  end

  always_comb begin
    step_d = step_q;
    if (bus.load_en)  step_d = clamp({1'b0, bus.load_value});
    else if (ev[0])   step_d = add_sat({1'b0, step_q}, INC_C);
    else if (ev[1])   step_d = sub_sat({1'b0, step_q}, INC_C);
    else if (ev[2])   step_d = add_sat({1'b0, step_q}, INC_M);
    else if (ev[3])   step_d = sub_sat({1'b0, step_q}, INC_M);
    else if (ev[4])   step_d = add_sat({1'b0, step_q}, INC_F);
    else if (ev[5])   step_d = sub_sat({1'b0, step_q}, INC_F);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q    <= '1;
      sync2_q    <= '1;
      deb_q      <= '1;
      deb_prev_q <= '1;
      for (int i = 0; i < 6; i++) begin
        db_cnt_q[i] <= '0;
        rp_cnt_q[i] <= '0;
      end
    end else begin
      sync1_q    <= bus.switch_n;
      sync2_q    <= sync1_q;
      deb_prev_q <= deb_q;
      for (int i = 0; i < 6; i++) begin
        if (sync2_q[i] == deb_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DB_LAST) begin
          deb_q[i]    <= sync2_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
        end

        if (deb_q[i])        rp_cnt_q[i] <= '0;
        else if (press[i])   rp_cnt_q[i] <= RP_DLY_LD;
        else if (rep_ev[i])  rp_cnt_q[i] <= RP_PER_LD;
        else                 rp_cnt_q[i] <= rp_cnt_q[i] - 1'b1;
      end
    end
  end

  // Flags are computed from the next value so they line up with the new Step.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      step_q    <= INIT_W;
      changed_q <= 1'b0;
      at_min_q  <= (STEP_INIT == STEP_MIN);
      at_max_q  <= (STEP_INIT == STEP_MAX);
    end else begin
      step_q    <= step_d;
      changed_q <= (step_d != step_q);
      at_min_q  <= (step_d == MIN_X[WIDTH-1:0]);
      at_max_q  <= (step_d == MAX_X[WIDTH-1:0]);
    end
  end

  assign bus.Step         = step_q;
  assign bus.step_changed = changed_q;
  assign bus.at_min       = at_min_q;
  assign bus.at_max       = at_max_q;

endmodule

// File: doc/dds_step_ctrl.md
Name: dds_step_ctrl

Overview:
- Clocked, parametrised successor to the DDS front-panel step control.
- Turns six active-low push-switches into a saturating phase-increment word for the DDS phase accumulator. The switches are coarse/medium/fine, each with add and sub.
- Adds to the previous control: synchronisers, per-switch debounce, single-step-per-press, hold-to-auto-repeat, fixed-priority arbitration and a synchronous host load.
- Outputs update flags for the display and accumulator logic.

Parameters:
- WIDTH, 32, step word width.
- STEP_MIN, 10000, lower clamp.
- STEP_MAX, 2000000, upper clamp.
- STEP_INIT, 10000, reset value; STEP_MIN <= STEP_INIT <= STEP_MAX < 2^WIDTH.
- INC_COARSE, 10000, coarse increment.
- INC_MID, 1000, medium increment.
- INC_FINE, 1, fine increment.
- DEBOUNCE_CYCLES, 500000, cycles a raw level must be stable before it is accepted; >= 1.
- REPEAT_DELAY, 25000000, hold cycles before the first auto-repeat; >= 1.
- REPEAT_PERIOD, 5000000, cycles between auto-repeats; >= 1.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- switch_n  input  6  raw switches, 0 = pressed, asynchronous to clk. Bit map: [0] coarse add, [1] coarse sub, [2] mid add, [3] mid sub, [4] fine add, [5] fine sub.
- load_en  input  1  synchronous host load strobe.
- load_value  input  WIDTH  host step value.
- Step  output  WIDTH  registered phase increment.
- step_changed  output  1  one-cycle pulse when Step takes a new value.
- at_min  output  1  registered, Step == STEP_MIN.
- at_max  output  1  registered, Step == STEP_MAX.

Behaviour:
- Reset (reset = 0, asynchronous) sets:
  - Step = STEP_INIT; step_changed = 0.
  - at_min/at_max set to match STEP_INIT.
  - All synchroniser flops = 1; debounced states = 1 (released).
  - All debounce and repeat counters = 0.
- Synchroniser: each switch_n bit passes through 2 flops before the debounce stage.
- Debounce, per bit:
  - A counter increments while the synchronised level differs from the debounced state.
  - The counter clears whenever the levels agree.
  - When the count reaches DEBOUNCE_CYCLES, the debounced state takes the new level and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES are ignored.
- Events, per bit:
  - Press event: debounced 1->0 transition, one cycle.
  - While the debounced state is 0, the repeat counter runs. The first repeat event fires REPEAT_DELAY cycles after the press event, then one every REPEAT_PERIOD cycles.
  - Release clears the repeat counter. No event on release.
- Arbitration, per cycle:
  - Priority: load_en > bit0 > bit1 > bit2 > bit3 > bit4 > bit5.
  - Only the winner is applied. Losing events that cycle are dropped, not queued.
  - Add and sub of the same group in the same cycle: add wins.
- Arithmetic is done in WIDTH+1 bits, with no wrap-around:
  - Add: Step' = min(Step + INC, STEP_MAX).
  - Sub: Step' = STEP_MIN if Step < STEP_MIN + INC, else Step - INC.
  - Load: Step' = load_value clamped to [STEP_MIN, STEP_MAX].
- Latency:
  - Step updates on the clk edge ending the cycle in which the winning event is present.
  - Press-to-Step is 2 (sync) + DEBOUNCE_CYCLES + 1 cycles.
  - load_en to Step is 1 cycle.
- Flags:
  - step_changed is registered alongside Step; it is 1 only if Step' != Step. A saturated add at STEP_MAX gives no pulse.
  - at_min/at_max are registered from Step', so they are valid in the same cycle as the new Step.
- A switch held through reset release is debounced to pressed after DEBOUNCE_CYCLES and then produces one press event. This is intended behaviour.
- Reset asserted mid-debounce or mid-repeat aborts all pending events.

Test Plan (bench parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8):
- Reset, then idle → Step=10000, at_min=1, at_max=0, step_changed=0.
- switch_n[0] low for 10 cycles, then released → exactly one update, Step=20000. step_changed pulses once, 7 cycles after the falling edge.
- Glitch of 3 cycles low on bit2 → no change. Then bit5 held 60 cycles from Step=10000 → Step stays 10000, at_min=1, no step_changed.
- Hold bit0 starting from Step=1980000 → first update gives 1990000. Repeats at +20 and +28 cycles give 2000000, then 2000000 with no pulse. at_max=1.
- Bit0 and bit1 pressed on the same cycle → only add applied (+10000). Bit0 event coinciding with load_en, load_value=5 → Step=10000 (clamped), press dropped.
- load_value=3000000 → Step=2000000. Then reset pulsed low mid-debounce of bit4 → Step=10000, no later update from that press.
